// File: rtl/core_ctrl_pkg.sv
// Shared constants and types for the core instruction sequencer.
// Holds the inst bit layout, the idle word, the FSM state type and the field bundle.
package core_ctrl_pkg;

  localparam int ADDR_W = 11;
  localparam int INST_W = 35;

  localparam int B_MODE     = 34;
  localparam int B_ACC      = 33;
  localparam int B_CEN_P    = 32;
  localparam int B_WEN_P    = 31;
  localparam int B_AP_LSB   = 20;
  localparam int B_CEN_X    = 19;
  localparam int B_WEN_X    = 18;
  localparam int B_AX_LSB   = 7;
  localparam int B_OFIFO_RD = 6;
  localparam int B_IFIFO_WR = 5;
  localparam int B_IFIFO_RD = 4;
  localparam int B_L0_RD    = 3;
  localparam int B_L0_WR    = 2;
  localparam int B_EXEC     = 1;
  localparam int B_LOAD     = 0;

  // Both SRAMs disabled, no writes, every strobe low.
  localparam logic [INST_W-1:0] IDLE_INST = 35'h1_800C_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_RD,
    S_W_LD,
    S_W_SETL,
    S_A_RD,
    S_EXEC,
    S_DRAIN,
    S_NEXT
  } state_e;

  typedef struct packed {
    logic              acc;
    logic              cen_p;
    logic              wen_p;
    logic [ADDR_W-1:0] a_p;
    logic              cen_x;
    logic              wen_x;
    logic [ADDR_W-1:0] a_x;
    logic              ofifo_rd;
    logic              l0_rd;
    logic              l0_wr;
    logic              execute;
    logic              load;
  } inst_f_t;

endpackage

// File: rtl/core_inst_seq_pack.sv
// Combinational packer: field bundle -> 35-bit core instruction word.
// Ports: f_i (fields), inst_o (packed word; mode_os and ififo strobes tied 0).
module inst_pack
  import core_ctrl_pkg::*;
(
  input  inst_f_t           f_i,
  output logic [INST_W-1:0] inst_o
);

  always_comb begin
    inst_o = IDLE_INST;
    inst_o[B_MODE]     = 1'b0;
    inst_o[B_ACC]      = f_i.acc;
    inst_o[B_CEN_P]    = f_i.cen_p;
    inst_o[B_WEN_P]    = f_i.wen_p;
    inst_o[B_AP_LSB +: ADDR_W] = f_i.a_p;
    inst_o[B_CEN_X]    = f_i.cen_x;
    inst_o[B_WEN_X]    = f_i.wen_x;
    inst_o[B_AX_LSB +: ADDR_W] = f_i.a_x;
    inst_o[B_OFIFO_RD] = f_i.ofifo_rd;
    inst_o[B_IFIFO_WR] = 1'b0;
    inst_o[B_IFIFO_RD] = 1'b0;
    inst_o[B_L0_RD]    = f_i.l0_rd;
    inst_o[B_L0_WR]    = f_i.l0_wr;
    inst_o[B_EXEC]     = f_i.execute;
    inst_o[B_LOAD]     = f_i.load;
  end

endmodule

// File: rtl/core_inst_seq.sv
// Weight-stationary tile sequencer driving the registered 35-bit core inst bus.
// Ports: clk, reset, start, cfg_* (tile config), ofifo_valid -> inst, busy, done.
module core_inst_seq
  import core_ctrl_pkg::*;
#(
  parameter int ROW      = 8,
  parameter int COL      = 8,
  parameter int L0_DEPTH = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [6:0]        cfg_nij,
  input  logic [3:0]        cfg_kij,
  input  logic [ADDR_W-1:0] cfg_w_base,
  input  logic [ADDR_W-1:0] cfg_x_base,
  input  logic [ADDR_W-1:0] cfg_p_base,
  input  logic              ofifo_valid,
  output logic [INST_W-1:0] inst,
  output logic              busy,
  output logic              done
);

  localparam logic [7:0] COL_LAST  = 8'(COL - 1);
  localparam logic [7:0] SETL_LAST = 8'(ROW + COL - 1);
  localparam logic [7:0] RC        = 8'(ROW + COL);
  localparam logic [6:0] NIJ_MAX   = 7'(L0_DEPTH);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [6:0]        j_q, j_d;
  logic [3:0]        kij_q, kij_d;
  logic [6:0]        nij_q;
  logic [3:0]        kijn_q;
  logic [ADDR_W-1:0] wb_q, xb_q, pb_q;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              xrd_q, xrd_d;
  logic [INST_W-1:0] inst_q, inst_d;

  logic              ld_cfg;
  logic [6:0]        nij_clamp;
  logic [7:0]        nij_w;
  logic [3:0]        kij_inc;
  logic [ADDR_W-1:0] kofs;
  inst_f_t           f;

  assign ld_cfg    = (state_q == S_IDLE) && start;
  assign nij_clamp = (cfg_nij > NIJ_MAX) ? NIJ_MAX : cfg_nij;
  assign nij_w     = {1'b0, nij_q};
  assign kij_inc   = kij_q + 4'd1;
  assign kofs      = ADDR_W'(kij_q) * ADDR_W'(COL);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    j_d     = j_q;
    kij_d   = kij_q;
    busy_d  = busy_q;
    done_d  = 1'b0;

    f       = '0;
    f.cen_p = 1'b1;
    f.wen_p = 1'b1;
    f.cen_x = 1'b1;
    f.wen_x = 1'b1;
    f.acc   = (state_q != S_IDLE) && (kij_q != 4'd0);
    // xmem data lands one cycle after the read; write it into L0 then.
    f.l0_wr = xrd_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          if (cfg_nij == 7'd0 || cfg_kij == 4'd0) begin
            done_d = 1'b1;
          end else begin
            state_d = S_W_RD;
            busy_d  = 1'b1;
            cnt_d   = '0;
            j_d     = '0;
            kij_d   = '0;
          end
        end
      end
      S_W_RD: begin
        f.cen_x = 1'b0;
        f.a_x   = wb_q + kofs + ADDR_W'(cnt_q);
        if (cnt_q == COL_LAST) begin
          cnt_d   = '0;
          state_d = S_W_LD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_W_LD: begin
        f.l0_rd = 1'b1;
        f.load  = 1'b1;
        if (cnt_q == COL_LAST) begin
          cnt_d   = '0;
          state_d = S_W_SETL;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_W_SETL: begin
        if (cnt_q == SETL_LAST) begin
          cnt_d   = '0;
          state_d = S_A_RD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_A_RD: begin
        f.cen_x = 1'b0;
        f.a_x   = xb_q + ADDR_W'(cnt_q);
        if (cnt_q == nij_w - 8'd1) begin
          cnt_d   = '0;
          state_d = S_EXEC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_EXEC: begin
        f.execute = 1'b1;
        f.l0_rd   = (cnt_q < nij_w);
        if (cnt_q == nij_w + RC - 8'd1) begin
          cnt_d   = '0;
          j_d     = '0;
          state_d = S_DRAIN;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DRAIN: begin
        if (ofifo_valid) begin
          f.ofifo_rd = 1'b1;
          f.cen_p    = 1'b0;
          f.wen_p    = 1'b0;
          f.a_p      = pb_q + ADDR_W'(j_q);
          j_d        = j_q + 7'd1;
          if (j_q == nij_q - 7'd1) state_d = S_NEXT;
        end
      end
      S_NEXT: begin
        kij_d = kij_inc;
        if (kij_inc == kijn_q) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          state_d = S_W_RD;
        end
      end
      default: state_d = S_IDLE;
    endcase

    xrd_d = ~f.cen_x;
  end

  inst_pack u_pack (
    .f_i    (f),
    .inst_o (inst_d)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      j_q     <= '0;
      kij_q   <= '0;
      nij_q   <= '0;
      kijn_q  <= '0;
      wb_q    <= '0;
      xb_q    <= '0;
      pb_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      xrd_q   <= 1'b0;
      inst_q  <= IDLE_INST;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      j_q     <= j_d;
      kij_q   <= kij_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      xrd_q   <= xrd_d;
      inst_q  <= inst_d;
      if (ld_cfg) begin
        nij_q  <= nij_clamp;
        kijn_q <= cfg_kij;
        wb_q   <= cfg_w_base;
        xb_q   <= cfg_x_base;
        pb_q   <= cfg_p_base;
      end
    end
  end

  assign inst = inst_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_core_inst_seq.sv
// Directed bench for core_inst_seq: table of tile configs with hand-computed
// totals, plus sequences for drain stalls, zero config, start-while-busy and reset.
module tb_core_inst_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [6:0]  cfg_nij;
  logic [3:0]  cfg_kij;
  logic [10:0] cfg_w_base, cfg_x_base, cfg_p_base;
  logic        ofifo_valid;
  logic [34:0] inst;
  logic        busy, done;

  localparam logic [34:0] IDLE_W = 35'h1_800C_0000;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  core_inst_seq dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .cfg_nij     (cfg_nij),
    .cfg_kij     (cfg_kij),
    .cfg_w_base  (cfg_w_base),
    .cfg_x_base  (cfg_x_base),
    .cfg_p_base  (cfg_p_base),
    .ofifo_valid (ofifo_valid),
    .inst        (inst),
    .busy        (busy),
    .done        (done)
  );

  typedef struct {
    int nij, kij, wb, xb, pb;
    int neff;
    int e_xrd, e_load, e_exec, e_l0rd, e_pw, e_cyc;
  } vec_t;

  vec_t vt[5];

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  // mode 0: ofifo_valid always 1; 1: valid on every third cycle;
  // 2: a second start pulse arrives mid-run.
  task automatic run_tile(input vec_t v, input int mode);
    logic [10:0] xq[$];
    logic [10:0] pq[$];
    bit          accq[$];
    logic [34:0] w;
    int n_load = 0, n_exec = 0, n_l0rd = 0, wr_bad = 0, bit_bad = 0;
    int busy_bad = 0, vbad = 0, ndone = 0, cyc = 0, extra = 0;
    int xmis = 0, pmis = 0, amis = 0, idx;
    bit prev_xrd = 0, vprev, got_done = 0, xr;

    cfg_nij    = 7'(v.nij);
    cfg_kij    = 4'(v.kij);
    cfg_w_base = 11'(v.wb);
    cfg_x_base = 11'(v.xb);
    cfg_p_base = 11'(v.pb);
    start       = 1'b1;
    ofifo_valid = 1'b1;
    vprev       = 1'b1;
    for (int n = 1; n <= 5000 && !got_done; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      w  = inst;
      xr = !w[19];
      if (xr) xq.push_back(w[17:7]);
      if (w[2] !== prev_xrd) wr_bad++;
      prev_xrd = xr;
      n_load += int'(w[0]);
      n_exec += int'(w[1]);
      n_l0rd += int'(w[3]);
      if (!w[32]) begin
        if (w[31] !== 1'b0 || w[6] !== 1'b1 || !vprev) vbad++;
        pq.push_back(w[30:20]);
        accq.push_back(w[33]);
      end else if (w[6]) begin
        vbad++;
      end
      if (w[34] || w[5] || w[4] || !w[18]) bit_bad++;
      if (done) begin
        got_done = 1;
        cyc = n;
        ndone++;
        if (busy) busy_bad++;
      end else if (!busy) begin
        busy_bad++;
      end
      if (mode == 2 && n == 10) begin
        start      = 1'b1;
        cfg_w_base = 11'd500;
        cfg_nij    = 7'd9;
      end
      if (mode == 2 && n == 11) begin
        start      = 1'b0;
        cfg_w_base = 11'(v.wb);
        cfg_nij    = 7'(v.nij);
      end
      ofifo_valid = (mode == 1) ? (n % 3 == 0) : 1'b1;
      vprev = ofifo_valid;
    end
    chk("done_reached", 64'(got_done), 64'd1);
    for (int n = 0; n < 4; n++) begin
      @(negedge clk);
      if (done) ndone++;
      if (!inst[19] || !inst[32] || busy) extra++;
    end
    chk("done_once", 64'(ndone), 64'd1);
    chk("quiet_after_done", 64'(extra), 64'd0);
    chk("idle_after_done", 64'(inst), 64'(IDLE_W));
    chk("xrd_count", 64'(xq.size()), 64'(v.e_xrd));
    chk("load_count", 64'(n_load), 64'(v.e_load));
    chk("exec_count", 64'(n_exec), 64'(v.e_exec));
    chk("l0rd_count", 64'(n_l0rd), 64'(v.e_l0rd));
    chk("pw_count", 64'(pq.size()), 64'(v.e_pw));
    chk("l0wr_delay", 64'(wr_bad), 64'd0);
    chk("fixed_bits", 64'(bit_bad), 64'd0);
    chk("busy_window", 64'(busy_bad), 64'd0);
    chk("pw_on_valid", 64'(vbad), 64'd0);
    if (mode != 1) chk("cycles", 64'(cyc), 64'(v.e_cyc));

    idx = 0;
    for (int k = 0; k < v.kij; k++) begin
      for (int i = 0; i < 8; i++) begin
        if (idx >= xq.size() || xq[idx] !== 11'(v.wb + k * 8 + i)) xmis++;
        idx++;
      end
      for (int i = 0; i < v.neff; i++) begin
        if (idx >= xq.size() || xq[idx] !== 11'(v.xb + i)) xmis++;
        idx++;
      end
    end
    chk("xaddr_seq", 64'(xmis), 64'd0);
    idx = 0;
    for (int k = 0; k < v.kij; k++) begin
      for (int j = 0; j < v.neff; j++) begin
        if (idx >= pq.size() || pq[idx] !== 11'(v.pb + j)) pmis++;
        if (idx >= accq.size() || accq[idx] !== (k != 0)) amis++;
        idx++;
      end
    end
    chk("paddr_seq", 64'(pmis), 64'd0);
    chk("acc_per_kij", 64'(amis), 64'd0);
    if (v.wb == 100 && xq.size() > 139) begin
      chk("kij3_first", 64'(xq[132]), 64'd124);
      chk("kij3_last", 64'(xq[139]), 64'd131);
    end
  endtask

  task automatic zero_cfg(input int nij, input int kij);
    int extra = 0;
    cfg_nij = 7'(nij);
    cfg_kij = 4'(kij);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("zero_done", 64'(done), 64'd1);
    chk("zero_busy", 64'(busy), 64'd0);
    for (int n = 0; n < 5; n++) begin
      @(negedge clk);
      if (done || busy || inst !== IDLE_W) extra++;
    end
    chk("zero_quiet", 64'(extra), 64'd0);
  endtask

  initial begin
    vt[0] = '{4, 1, 0, 16, 0, 4, 12, 8, 20, 12, 4, 62};
    vt[1] = '{36, 9, 100, 500, 300, 36, 396, 72, 468, 396, 324, 1414};
    vt[2] = '{4, 1, 2040, 2045, 2046, 4, 12, 8, 20, 12, 4, 62};
    vt[3] = '{100, 2, 8, 1000, 10, 64, 144, 16, 160, 144, 128, 483};
    vt[4] = '{1, 3, 0, 0, 0, 1, 27, 24, 51, 27, 3, 157};

    reset = 1'b1;
    start = 1'b0;
    cfg_nij = '0;
    cfg_kij = '0;
    cfg_w_base = '0;
    cfg_x_base = '0;
    cfg_p_base = '0;
    ofifo_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_inst", 64'(inst), 64'(IDLE_W));
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int t = 0; t < 5; t++) run_tile(vt[t], 0);

    run_tile(vt[0], 1);
    run_tile(vt[0], 2);

    zero_cfg(0, 3);
    zero_cfg(5, 0);

    begin
      int guard = 0;
      int extra = 0;
      cfg_nij = 7'd4;
      cfg_kij = 4'd2;
      cfg_w_base = '0;
      cfg_x_base = 11'd16;
      cfg_p_base = '0;
      ofifo_valid = 1'b1;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      while (!inst[1] && guard < 300) begin
        @(negedge clk);
        guard++;
      end
      chk("exec_seen", 64'(inst[1]), 64'd1);
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_inst", 64'(inst), 64'(IDLE_W));
      chk("abort_busy", 64'(busy), 64'd0);
      reset = 1'b0;
      for (int n = 0; n < 6; n++) begin
        @(negedge clk);
        if (inst !== IDLE_W || busy || done) extra++;
      end
      chk("abort_quiet", 64'(extra), 64'd0);
    end

    run_tile(vt[2], 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
